// File: rtl/data_mem_controller.sv
// Data memory controller: single-port 32-bit word array behind a
// three-state access FSM with programmable wait states, a combinational
// processor stall and a registered reject pulse for malformed requests.
module data_mem_controller #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data,
  output logic        hold,
  output logic        addr_error
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [31:0]            wdata_q;
  logic                   we_q;     // latched operation: 1 = store, 0 = load
  logic [31:0]            data_q;
  logic                   err_q;

  logic [31:0]            mem [DEPTH];

  logic req_valid, req_reject, access_d;
  logic unused_addr;

  // A request is accepted only with exactly one strobe and a word-aligned address.
  assign req_valid  = (mem_read ^ mem_write) & (data_address[1:0] == 2'b00);
  assign req_reject = (mem_read | mem_write) & ~req_valid;
  // The array is touched in the last BUSY cycle only.
  assign access_d   = (state_q == BUSY) && (cnt_q == 4'd0);

  // High address bits are dropped so accesses wrap modulo the array size.
  assign unused_addr = ^data_address[31:DEPTH_LOG2+2];

  // Access FSM with latched request, wait counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            idx_q   <= data_address[DEPTH_LOG2+1:2];
            wdata_q <= write_data;
            we_q    <= mem_write;
            cnt_q   <= WS;
            state_q <= BUSY;
          end else if (req_reject) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!we_q) data_q <= mem[idx_q];
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array write port; no reset so contents survive a controller reset, and
  // a store aborted by reset never reaches here because the FSM is forced to IDLE.
  always_ff @(posedge clk) begin
    if (access_d && we_q) mem[idx_q] <= wdata_q;
  end

  // Stall is combinational so the processor freezes in the accepting cycle;
  // reset masks it immediately even if a valid request is still on the bus.
  assign hold       = ~reset & (((state_q == IDLE) & req_valid) | (state_q == BUSY));
  assign data       = data_q;
  assign addr_error = err_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench: two controllers (default wait states and zero wait
// states) share stimulus; a word-array model predicts loads and stall length.
module tb_data_mem_controller;

  localparam int W     = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_address, write_data;
  logic        mem_read, mem_write;
  logic [31:0] data, data_b;
  logic        hold, hold_b, addr_error, addr_error_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] memA [DEPTH];
  logic [31:0] memB [DEPTH];
  logic [31:0] dA_m, dB_m;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wd;
    int          exp_hold;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];

  data_mem_controller #(.DEPTH_LOG2(6), .WAIT_STATES(W)) u_dut (
    .clk(clk), .reset(reset), .data_address(data_address), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .data(data), .hold(hold),
    .addr_error(addr_error));

  data_mem_controller #(.DEPTH_LOG2(6), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .data_address(data_address), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .data(data_b), .hold(hold_b),
    .addr_error(addr_error_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd);
    int idx;
    idx = int'((addr / 4) % DEPTH);
    if ((rd != wr) && (addr % 4 == 0)) begin
      if (wr) begin
        memA[idx] = wd;
        memB[idx] = wd;
      end else begin
        dA_m = memA[idx];
        dB_m = memB[idx];
      end
    end
  endtask

  task automatic add_vec(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int h, input logic [31:0] d,
                         input logic e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.exp_hold = h; v.exp_data = d; v.exp_err = e;
    tbl.push_back(v);
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd);
    mem_read = rd; mem_write = wr; data_address = addr; write_data = wd;
  endtask

  task automatic drive_noise();
    mem_read     = 1'($urandom_range(0, 1));
    mem_write    = 1'($urandom_range(0, 1));
    data_address = $urandom;
    write_data   = $urandom;
  endtask

  // Called just after a rising edge. Returns stall counts of both DUTs, data
  // and addr_error in the completion cycle, and addr_error one cycle later.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input bit noise,
                            output int hA, output int hB,
                            output logic [31:0] dA, output logic [31:0] dB,
                            output logic eA, output logic eB,
                            output logic e2A, output logic e2B);
    bit done;
    done = 0; hA = 0; hB = 0;
    set_req(rd, wr, addr, wd);
    @(negedge clk);
    if (hold) hA++;
    if (hold_b) hB++;
    @(posedge clk); #1;
    if (noise) drive_noise(); else set_req(0, 0, 0, 0);
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (hold_b) hB++;
      if (!hold) begin
        done = 1;
        break;
      end
      hA++;
      @(posedge clk); #1;
      if (noise && k == 1) drive_noise(); else set_req(0, 0, 0, 0);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: hold never dropped within 40 cycles");
    end
    set_req(0, 0, 0, 0);
    dA = data; dB = data_b; eA = addr_error; eB = addr_error_b;
    @(posedge clk); #1;
    @(negedge clk);
    e2A = addr_error; e2B = addr_error_b;
    @(posedge clk); #1;
  endtask

  initial begin
    int hA, hB;
    logic [31:0] dA, dB, a, v;
    logic eA, eB, e2A, e2B, rd, wr, valid;
    bit noise;
    logic [31:0] b2b_addr [3];
    logic        b2b_wr [3];
    logic [31:0] b2b_wd [3];

    for (int i = 0; i < DEPTH; i++) begin
      memA[i] = 32'd0;
      memB[i] = 32'd0;
    end
    dA_m = 32'd0; dB_m = 32'd0;

    //            rd wr addr          wdata          hold data           err
    add_vec(0, 1, 32'h0000_0010, 32'hDEADBEEF, 4, 32'h0000_0000, 0);
    add_vec(1, 0, 32'h0000_0010, 32'h0,        4, 32'hDEADBEEF, 0);
    add_vec(0, 1, 32'h0000_0104, 32'h11111111, 4, 32'hDEADBEEF, 0);
    add_vec(1, 0, 32'h0000_0004, 32'h0,        4, 32'h11111111, 0);
    add_vec(0, 1, 32'h0000_0000, 32'hA5A5A5A5, 4, 32'h11111111, 0);
    add_vec(1, 0, 32'h0000_0013, 32'h0,        0, 32'h11111111, 1);
    add_vec(1, 1, 32'h0000_0000, 32'h55555555, 0, 32'h11111111, 1);
    add_vec(0, 1, 32'h0000_0012, 32'h77777777, 0, 32'h11111111, 1);
    add_vec(1, 0, 32'h0000_0000, 32'h0,        4, 32'hA5A5A5A5, 0);
    add_vec(1, 0, 32'h0000_0010, 32'h0,        4, 32'hDEADBEEF, 0);
    add_vec(1, 0, 32'hFFFF_FF04, 32'h0,        4, 32'h11111111, 0);

    // Reset state, with a valid request present to show hold is masked.
    reset = 1'b1;
    set_req(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 set_req(1, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_hold_b", {31'd0, hold_b}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_err", {31'd0, addr_error}, 32'd0);
    set_req(0, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, 0,
                 hA, hB, dA, dB, eA, eB, e2A, e2B);
      chk($sformatf("vec%0d_hold", i), 32'(hA), 32'(tbl[i].exp_hold));
      chk($sformatf("vec%0d_hold_b", i), 32'(hB), (tbl[i].exp_hold > 0) ? 32'd2 : 32'd0);
      chk($sformatf("vec%0d_data", i), dA, tbl[i].exp_data);
      chk($sformatf("vec%0d_data_b", i), dB, tbl[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'd0, eA}, {31'd0, tbl[i].exp_err});
      chk($sformatf("vec%0d_err_b", i), {31'd0, eB}, {31'd0, tbl[i].exp_err});
      chk($sformatf("vec%0d_err_pulse", i), {30'd0, e2A, e2B}, 32'd0);
    end

    // Fill every word so later random loads have defined contents.
    for (int i = 0; i < DEPTH; i++) begin
      a = ($urandom & 32'hFFFF_FF00) | 32'(i * 4);
      v = $urandom;
      model_apply(0, 1, a, v);
      run_access(0, 1, a, v, 0, hA, hB, dA, dB, eA, eB, e2A, e2B);
      chk("fill_hold", 32'(hA), 32'(W + 2));
    end

    // Randomized traffic, with bus noise during BUSY for accepted requests.
    for (int n = 0; n < 200; n++) begin
      if (n == 120) begin
        // Store committed by the zero-wait DUT, aborted by reset in the other.
        model_apply(0, 1, 32'h20, 32'h0);
        run_access(0, 1, 32'h20, 32'h0, 0, hA, hB, dA, dB, eA, eB, e2A, e2B);
        chk("abort_pre_hold", 32'(hA), 32'(W + 2));
        set_req(0, 1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        chk("abort_accept_hold", {31'd0, hold}, 32'd1);
        @(posedge clk); #1 set_req(0, 0, 0, 0);
        @(negedge clk);
        chk("abort_busy1_hold", {31'd0, hold}, 32'd1);
        @(posedge clk); #1;
        #1 chk("abort_busy2_hold", {31'd0, hold}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_hold_async", {31'd0, hold}, 32'd0);
        chk("abort_data", data, 32'd0);
        chk("abort_data_b", data_b, 32'd0);
        chk("abort_err", {31'd0, addr_error}, 32'd0);
        memB[8] = 32'hCAFEF00D;
        dA_m = 32'd0; dB_m = 32'd0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        model_apply(1, 0, 32'h20, 32'h0);
        run_access(1, 0, 32'h20, 32'h0, 0, hA, hB, dA, dB, eA, eB, e2A, e2B);
        chk("abort_load", dA, 32'h0000_0000);
        chk("abort_load_b", dB, 32'hCAFEF00D);
      end
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       begin rd = 1; wr = 1; end
        1:       begin rd = 1'($urandom_range(0, 1)); wr = ~rd;
                       a[1:0] = 2'($urandom_range(1, 3)); end
        default: begin rd = 1'($urandom_range(0, 1)); wr = ~rd; a[1:0] = 2'b00; end
      endcase
      v = $urandom;
      valid = (rd != wr) && (a % 4 == 0);
      noise = valid && ($urandom_range(0, 1) == 1);
      model_apply(rd, wr, a, v);
      run_access(rd, wr, a, v, noise, hA, hB, dA, dB, eA, eB, e2A, e2B);
      chk("rnd_hold", 32'(hA), valid ? 32'(W + 2) : 32'd0);
      chk("rnd_hold_b", 32'(hB), valid ? 32'd2 : 32'd0);
      chk("rnd_data", dA, dA_m);
      chk("rnd_data_b", dB, dB_m);
      chk("rnd_err", {30'd0, eA, eB}, valid ? 32'd0 : 32'd3);
      chk("rnd_err_pulse", {30'd0, e2A, e2B}, 32'd0);
    end

    // Zero-wait DUT: load/store/load held back-to-back on the bus.
    v = $urandom;
    b2b_addr[0] = 32'h40; b2b_wr[0] = 0; b2b_wd[0] = 32'h0;
    b2b_addr[1] = 32'h44; b2b_wr[1] = 1; b2b_wd[1] = v;
    b2b_addr[2] = 32'h44; b2b_wr[2] = 0; b2b_wd[2] = 32'h0;
    set_req(~b2b_wr[0], b2b_wr[0], b2b_addr[0], b2b_wd[0]);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_accept_hold", r), {31'd0, hold_b}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("b2b%0d_busy_hold", r), {31'd0, hold_b}, 32'd1);
      @(posedge clk); #1;
      model_apply(~b2b_wr[r], b2b_wr[r], b2b_addr[r], b2b_wd[r]);
      if (r < 2) set_req(~b2b_wr[r+1], b2b_wr[r+1], b2b_addr[r+1], b2b_wd[r+1]);
      else set_req(0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("b2b%0d_resp_hold", r), {31'd0, hold_b}, 32'd0);
      chk($sformatf("b2b%0d_data", r), data_b, dB_m);
      chk($sformatf("b2b%0d_err", r), {31'd0, addr_error_b}, 32'd0);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
